// File: rtl/bfly_pkg.sv
// Shared types and helpers for the butterfly serial collector.
//   fp16_t            : one fp16 element
//   collector_state_e : collector FSM states
//   lane_slot_lsb()   : bit offset of (lane, slot) inside the packed output word
package bfly_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } collector_state_e;

    // Lane g owns PACK consecutive slots; slot s of lane g starts at this bit.
    function automatic int lane_slot_lsb(input int g, input int s,
                                         input int pack, input int data_width);
        return (g * pack + s) * data_width;
    endfunction

endpackage

// File: rtl/bfly_lane_packer.sv
// Per-lane pack register for the serial collector.
// Ports:
//   clk, rst   : clock, async active-high reset
//   clr        : clears the pack register (new run)
//   wr_en      : a beat is accepted this cycle
//   word_done  : the accepted beat completes the current word
//   slot       : slot index the current beat lands in
//   din        : this lane's element of the current beat
//   word       : assembled word = stored slots below `slot`, din at `slot`,
//                zeros above (only non-zero padding case is the short final word)
module bfly_lane_packer
    import bfly_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PACK       = 4,
    localparam int SW        = $clog2(PACK)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic                       word_done,
    input  logic [SW-1:0]              slot,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [PACK*DATA_WIDTH-1:0] word
);

    logic [PACK*DATA_WIDTH-1:0] pack_q;

    always_comb begin
        word = '0;
        for (int s = 0; s < PACK; s++) begin
            if (SW'(s) == slot)
                word[s*DATA_WIDTH +: DATA_WIDTH] = din;
            else if (SW'(s) < slot)
                word[s*DATA_WIDTH +: DATA_WIDTH] = pack_q[s*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The register is emptied once its word is handed off, so stale data from
    // the previous word can never leak into a later word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q <= '0;
        end else if (clr) begin
            pack_q <= '0;
        end else if (wr_en) begin
            if (word_done)
                pack_q <= '0;
            else
                pack_q[slot*DATA_WIDTH +: DATA_WIDTH] <= din;
        end
    end

endmodule

// File: rtl/bfly_serial_collector.sv
// Collects the butterfly processor's serial output, packs PACK elements per
// lane into one wide word and streams the words downstream.
// Ports:
//   clk, rst        : clock, async active-high reset
//   start, length   : start pulse and per-lane element count for the run
//   up_vld/up_dat   : serial beat in (beat present when any up_vld bit set)
//   up_rdy          : serial ready
//   dn_vld/dn_dat   : packed word out, dn_last marks the final word
//   dn_rdy          : downstream ready
//   busy            : run in progress (through the done pulse)
//   done            : final word accepted downstream
//   err_len         : start seen with length == 0
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; no beats accepted
// RUN   | accepting beats, emitting full words
// DRAIN | final word loaded, waiting for downstream to take it
module bfly_serial_collector
    import bfly_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int BE_PARALLELISM  = 32,
    parameter int PACK            = 4,
    parameter int OUTPUT_AXI_CHNL = 8,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [LEN_WIDTH-1:0]                      length,
    input  logic [OUTPUT_AXI_CHNL-1:0]                up_vld,
    input  logic [DATA_WIDTH*BE_PARALLELISM-1:0]      up_dat,
    output logic                                      up_rdy,
    output logic                                      dn_vld,
    output logic [DATA_WIDTH*PACK*BE_PARALLELISM-1:0] dn_dat,
    output logic                                      dn_last,
    input  logic                                      dn_rdy,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err_len
);

    localparam int SW  = $clog2(PACK);
    localparam int DNW = DATA_WIDTH * PACK * BE_PARALLELISM;

    collector_state_e     state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] elem_q;
    logic [SW-1:0]        slot_q;
    logic [DNW-1:0]       packed_word;
    logic                 beat_acc;
    logic                 last_elem;
    logic                 word_done;
    logic                 start_ok;

    // Ready passes straight through from dn_rdy so a word can be replaced on
    // the same edge it is taken, keeping one beat per cycle.
    assign up_rdy    = (state == RUN) && (!dn_vld || dn_rdy);
    assign beat_acc  = (|up_vld) && up_rdy;
    assign last_elem = (elem_q == (len_q - LEN_WIDTH'(1)));
    assign word_done = (slot_q == SW'(PACK - 1)) || last_elem;
    assign start_ok  = (state == IDLE) && start && (length != '0);

    for (genvar g = 0; g < BE_PARALLELISM; g++) begin : g_lane
        bfly_lane_packer #(
            .DATA_WIDTH (DATA_WIDTH),
            .PACK       (PACK)
        ) u_packer (
            .clk       (clk),
            .rst       (rst),
            .clr       (start_ok),
            .wr_en     (beat_acc),
            .word_done (word_done),
            .slot      (slot_q),
            .din       (up_dat[g*DATA_WIDTH +: DATA_WIDTH]),
            .word      (packed_word[lane_slot_lsb(g, 0, PACK, DATA_WIDTH) +: PACK*DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            elem_q  <= '0;
            slot_q  <= '0;
            dn_vld  <= 1'b0;
            dn_last <= 1'b0;
            dn_dat  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_len <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            // busy covers the done cycle, then drops unless a new run starts
            if (done)
                busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            err_len <= 1'b1;
                        end else begin
                            len_q  <= length;
                            elem_q <= '0;
                            slot_q <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (dn_vld && dn_rdy) begin
                        dn_vld  <= 1'b0;
                        dn_last <= 1'b0;
                    end
                    if (beat_acc) begin
                        elem_q <= elem_q + LEN_WIDTH'(1);
                        slot_q <= slot_q + SW'(1);
                        if (word_done) begin
                            dn_dat  <= packed_word;
                            dn_vld  <= 1'b1;
                            dn_last <= last_elem;
                        end
                        if (last_elem) begin
                            slot_q <= '0;
                            state  <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (dn_vld && dn_rdy && dn_last) begin
                        done    <= 1'b1;
                        dn_vld  <= 1'b0;
                        dn_last <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bfly_serial_collector.sv
`timescale 1ns/1ps
module tb_bfly_serial_collector;

    localparam int DW   = 16;
    localparam int BEP  = 32;
    localparam int PACK = 4;
    localparam int CH   = 8;
    localparam int LW   = 16;
    localparam int UPW  = DW * BEP;
    localparam int DNW  = UPW * PACK;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [LW-1:0]  length = '0;
    logic [CH-1:0]  up_vld = '0;
    logic [UPW-1:0] up_dat = '0;
    logic           up_rdy;
    logic           dn_vld;
    logic [DNW-1:0] dn_dat;
    logic           dn_last;
    logic           dn_rdy = 1'b0;
    logic           busy;
    logic           done;
    logic           err_len;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bfly_serial_collector #(
        .DATA_WIDTH      (DW),
        .BE_PARALLELISM  (BEP),
        .PACK            (PACK),
        .OUTPUT_AXI_CHNL (CH),
        .LEN_WIDTH       (LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .length  (length),
        .up_vld  (up_vld),
        .up_dat  (up_dat),
        .up_rdy  (up_rdy),
        .dn_vld  (dn_vld),
        .dn_dat  (dn_dat),
        .dn_last (dn_last),
        .dn_rdy  (dn_rdy),
        .busy    (busy),
        .done    (done),
        .err_len (err_len)
    );

    // One run: length, data offset, back-pressure on/off, restart injection,
    // and the hand-computed number of output words.
    typedef struct {
        int len;
        int off;
        int bp;
        int restart;
        int exp_words;
    } run_t;

    run_t runs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [DNW-1:0] exp_word(input int len, input int off, input int w);
        logic [DNW-1:0] r;
        int e;
        r = '0;
        for (int g = 0; g < BEP; g++) begin
            for (int s = 0; s < PACK; s++) begin
                e = w * PACK + s;
                if (e < len)
                    r[(g*PACK+s)*DW +: DW] = DW'(g * 256 + e + off);
            end
        end
        return r;
    endfunction

    task automatic drive_beat(input int j, input int len, input int off);
        if (j < len) begin
            up_vld = CH'(1) << (j % CH);
            for (int g = 0; g < BEP; g++)
                up_dat[g*DW +: DW] = DW'(g * 256 + j + off);
        end else begin
            // junk beat that must never be consumed
            up_vld = '1;
            for (int g = 0; g < BEP; g++)
                up_dat[g*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic check_word(input int w, input int len, input int off);
        logic [DNW-1:0] ew;
        bit reported;
        ew = exp_word(len, off, w);
        checks++;
        if (dn_dat !== ew) begin
            errors++;
            reported = 1'b0;
            for (int g = 0; g < BEP && !reported; g++) begin
                for (int s = 0; s < PACK && !reported; s++) begin
                    if (dn_dat[(g*PACK+s)*DW +: DW] !== ew[(g*PACK+s)*DW +: DW]) begin
                        $display("FAIL word%0d lane%0d slot%0d: actual=%0d required=%0d",
                                 w, g, s, dn_dat[(g*PACK+s)*DW +: DW], ew[(g*PACK+s)*DW +: DW]);
                        reported = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic do_run(input run_t r);
        int j;
        int w;
        int cyc;
        bit fin;
        bit acc;
        bit exp_rdy;
        bit stall_prev;
        bit done_due;
        bit post_done;
        logic [DNW-1:0] prev_dat;
        logic prev_last;

        j = 0; w = 0; cyc = 0;
        fin = 0; stall_prev = 0; done_due = 0; post_done = 0;
        prev_dat = '0; prev_last = 1'b0;

        @(posedge clk); #1;
        start  = 1'b1;
        length = LW'(r.len);
        dn_rdy = 1'b1;
        drive_beat(0, r.len, r.off);
        @(posedge clk); #1;
        start = 1'b0;

        while (cyc < 4000) begin
            @(negedge clk);
            if (cyc == 0)
                chk("busy_in_run", busy, 1);
            exp_rdy = (j < r.len) ? (!dn_vld || dn_rdy) : 1'b0;
            chk("up_rdy", up_rdy, exp_rdy);
            if (stall_prev) begin
                chk("hold_vld", dn_vld, 1);
                chk("hold_dat", (dn_dat === prev_dat), 1);
                chk("hold_last", dn_last, prev_last);
            end
            if (post_done) begin
                chk("done_clear", done, 0);
                chk("busy_clear", busy, 0);
                fin = 1;
            end else if (done_due) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 1);
                post_done = 1;
            end else if (done) begin
                chk("done_early", done, 0);
            end
            if (fin)
                break;

            acc = (up_vld != '0) && up_rdy;
            if (dn_vld && dn_rdy) begin
                if (w >= r.exp_words) begin
                    chk("extra_word", w, r.exp_words - 1);
                end else begin
                    check_word(w, r.len, r.off);
                    chk("dn_last", dn_last, (w == r.exp_words - 1));
                    if (w == r.exp_words - 1)
                        done_due = 1;
                end
                w++;
            end
            stall_prev = dn_vld && !dn_rdy;
            prev_dat   = dn_dat;
            prev_last  = dn_last;

            @(posedge clk); #1;
            if (acc)
                j++;
            drive_beat(j, r.len, r.off);
            dn_rdy = r.bp != 0 ? ((((cyc + 1) / 3) % 2) == 0) : 1'b1;
            start  = (r.restart != 0) && (cyc == 20);
            if (start)
                length = LW'(8);
            cyc++;
        end

        if (!fin)
            chk("run_timeout", 0, 1);
        chk("word_count", w, r.exp_words);
        chk("beat_count", j, r.len);
        start  = 1'b0;
        up_vld = '0;
    endtask

    initial begin
        run_t rr;
        int j;
        int budget;
        bit acc;

        runs[0] = '{len: 256, off: 0, bp: 0, restart: 0, exp_words: 64};
        runs[1] = '{len: 256, off: 0, bp: 1, restart: 0, exp_words: 64};
        runs[2] = '{len: 6,   off: 1, bp: 0, restart: 0, exp_words: 2};
        runs[3] = '{len: 256, off: 0, bp: 0, restart: 1, exp_words: 64};
        runs[4] = '{len: 5,   off: 3, bp: 1, restart: 0, exp_words: 2};
        runs[5] = '{len: 9,   off: 2, bp: 1, restart: 0, exp_words: 3};
        runs[6] = '{len: 1,   off: 7, bp: 0, restart: 0, exp_words: 1};

        // reset state
        #12;
        chk("rst_up_rdy", up_rdy, 0);
        chk("rst_dn_vld", dn_vld, 0);
        chk("rst_dn_last", dn_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_dn_dat_zero", (dn_dat == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            do_run(runs[i]);

        // zero length start
        @(posedge clk); #1;
        start  = 1'b1;
        length = '0;
        up_vld = '1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_err_len", err_len, 1);
        chk("zero_busy", busy, 0);
        chk("zero_up_rdy", up_rdy, 0);
        @(posedge clk); #1;
        chk("zero_err_len_clear", err_len, 0);
        chk("zero_busy_after", busy, 0);
        chk("zero_up_rdy_after", up_rdy, 0);
        up_vld = '0;

        // reset after 10 accepted beats of a long run
        @(posedge clk); #1;
        start  = 1'b1;
        length = LW'(256);
        dn_rdy = 1'b1;
        drive_beat(0, 256, 0);
        @(posedge clk); #1;
        start = 1'b0;
        j = 0;
        budget = 0;
        while (j < 10 && budget < 100) begin
            @(negedge clk);
            acc = (up_vld != '0) && up_rdy;
            @(posedge clk); #1;
            if (acc)
                j++;
            drive_beat(j, 256, 0);
            budget++;
        end
        chk("pre_reset_beats", j, 10);
        chk("pre_reset_dat_loaded", (dn_dat != '0), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_up_rdy", up_rdy, 0);
        chk("mid_rst_dn_vld", dn_vld, 0);
        chk("mid_rst_dn_last", dn_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err_len", err_len, 0);
        chk("mid_rst_dn_dat_zero", (dn_dat == '0), 1);
        up_vld = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        rr = '{len: 4, off: 5, bp: 0, restart: 0, exp_words: 1};
        do_run(rr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
